// File: rtl/rca_pkg.sv
/*=============================================================================
 * Module   : rca_pkg
 * Brief    : Shared FSM encoding and WIDTH/SEG legality check for seg_rca_adder.
 * Revision : 1.0
 *===========================================================================*/
`default_nettype none

package rca_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic bit seg_cfg_ok(input int width, input int seg);
    return (seg >= 1) && (width >= seg) && ((width % seg) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rca_seg.sv
/*=============================================================================
 * Module   : rca_seg
 * Brief    : SEG-bit combinational ripple-carry slice with carry into the MSB.
 * Revision : 1.0
 *===========================================================================*/
`default_nettype none

module rca_seg #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           c_msb_in
);

  // A scalar running carry keeps the ripple free of vector self-dependency.
  always_comb begin
    logic c;
    s        = '0;
    c_msb_in = 1'b0;
    c        = ci;
    for (int i = 0; i < SEG; i++) begin
      if (i == SEG - 1) c_msb_in = c;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

`default_nettype wire

// File: rtl/seg_rca_adder.sv
/*=============================================================================
 * Module   : seg_rca_adder
 * Brief    : Multi-cycle add/subtract, SEG bits per cycle through one shared slice.
 * Revision : 1.0
 *===========================================================================*/
`default_nettype none

module seg_rca_adder
  import rca_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = (SEG >= 1) ? (WIDTH / SEG) : 1;
  localparam int c_KW = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [c_KW-1:0] c_KLAST = c_KW'(NSEG - 1);

  if (!seg_cfg_ok(WIDTH, SEG)) begin : g_cfg_err
    $error("seg_rca_adder: WIDTH must be a positive multiple of SEG");
  end

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic              r_carry;
  logic [c_KW-1:0]   r_k;
  logic [WIDTH-1:0]  r_sum;
  logic              r_cout;
  logic              r_ovf;

  logic [SEG-1:0]    w_seg_a;
  logic [SEG-1:0]    w_seg_b;
  logic [SEG-1:0]    w_seg_s;
  logic              w_seg_co;
  logic              w_seg_cmsb;

  assign w_seg_a = r_a[r_k*SEG +: SEG];
  assign w_seg_b = r_b[r_k*SEG +: SEG];

  rca_seg #(.SEG(SEG)) u_seg (
    .a        (w_seg_a),
    .b        (w_seg_b),
    .ci       (r_carry),
    .s        (w_seg_s),
    .co       (w_seg_co),
    .c_msb_in (w_seg_cmsb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)         w_state_nxt = ST_RUN;
      ST_RUN:  if (r_k == c_KLAST)   w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready)        w_state_nxt = ST_IDLE;
      default:                       w_state_nxt = ST_IDLE;
    endcase
  end

  // Subtraction is a + ~b + ~borrow, so cout reads as "no borrow".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_k     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? ~cin : cin;
            r_k     <= '0;
          end
        end
        ST_RUN: begin
          r_sum[r_k*SEG +: SEG] <= w_seg_s;
          r_carry               <= w_seg_co;
          r_k                   <= r_k + 1'b1;
          if (r_k == c_KLAST) begin
            r_cout <= w_seg_co;
            r_ovf  <= w_seg_co ^ w_seg_cmsb;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_seg_rca_adder.sv
/*=============================================================================
 * Module   : tb_seg_rca_adder
 * Brief    : Randomized self-checking bench for seg_rca_adder (16/4 and 6/3).
 * Revision : 1.0
 *===========================================================================*/
`default_nettype none

module tb_seg_rca_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        iv16 = 1'b0, or16 = 1'b0, ci16 = 1'b0, sb16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        ir16, ov16, co16, of16;
  logic [15:0] s16;

  logic        iv6 = 1'b0, or6 = 1'b0, ci6 = 1'b0, sb6 = 1'b0;
  logic [5:0]  a6 = '0, b6 = '0;
  logic        ir6, ov6, co6, of6;
  logic [5:0]  s6;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seg_rca_adder #(.WIDTH(16), .SEG(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .cin(ci16), .sub(sb16),
    .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16), .ovf(of16)
  );

  seg_rca_adder #(.WIDTH(6), .SEG(3)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv6), .in_ready(ir6),
    .a(a6), .b(b6), .cin(ci6), .sub(sb6),
    .out_valid(ov6), .out_ready(or6), .sum(s6), .cout(co6), .ovf(of6)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: integer arithmetic on the operands; overflow = signed result out of range.
  task automatic model(input int w, input int a, input int b, input int ci, input int sb,
                       output int s, output int co, output int ov);
    longint mask, full, sa, sbv, res;
    mask = (64'sd1 <<< w) - 1;
    full = sb ? (longint'(a) - b - ci) : (longint'(a) + b + ci);
    s    = int'(full & mask);
    co   = sb ? int'(full >= 0) : int'(full > mask);
    sa   = (a >= (1 << (w-1))) ? longint'(a) - (64'sd1 <<< w) : longint'(a);
    sbv  = (b >= (1 << (w-1))) ? longint'(b) - (64'sd1 <<< w) : longint'(b);
    res  = sb ? (sa - sbv - ci) : (sa + sbv + ci);
    ov   = int'((res > (64'sd1 <<< (w-1)) - 1) || (res < -(64'sd1 <<< (w-1))));
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic ci,
                       input logic sb, input int hold);
    int es, ec, eo, lat;
    logic [15:0] hs;
    logic hc, ho;
    model(16, int'(a), int'(b), int'(ci), int'(sb), es, ec, eo);
    @(negedge clk);
    check("ready16", 32'(ir16), 32'd1);
    a16 = a; b16 = b; ci16 = ci; sb16 = sb; iv16 = 1'b1; or16 = 1'b0;
    @(posedge clk); #1;
    iv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); ci16 = 1'($urandom); sb16 = 1'($urandom);
    lat = 0;
    while (!ov16 && lat < 40) begin @(posedge clk); #1; lat++; end
    check("lat16", 32'(lat), 32'd4);
    check("sum16", 32'(s16), 32'(es));
    check("cout16", 32'(co16), 32'(ec));
    check("ovf16", 32'(of16), 32'(eo));
    hs = s16; hc = co16; ho = of16;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      iv16 = ~iv16; a16 = 16'($urandom); b16 = 16'($urandom);
      @(posedge clk); #1;
      check("hold16", {14'd0, ov16, ir16, hs}, {14'd0, 1'b1, 1'b0, 16'(es)});
      check("holdf16", {30'd0, co16, of16}, {30'd0, hc, ho});
    end
    @(negedge clk);
    iv16 = 1'b0; or16 = 1'b1;
    @(posedge clk); #1;
    or16 = 1'b0;
    check("back16", {30'd0, ov16, ir16}, 32'd1);
  endtask

  task automatic run6(input logic [5:0] a, input logic [5:0] b, input logic ci, input logic sb);
    int es, ec, eo, lat;
    model(6, int'(a), int'(b), int'(ci), int'(sb), es, ec, eo);
    @(negedge clk);
    a6 = a; b6 = b; ci6 = ci; sb6 = sb; iv6 = 1'b1; or6 = 1'b0;
    @(posedge clk); #1;
    iv6 = 1'b0;
    lat = 0;
    while (!ov6 && lat < 40) begin @(posedge clk); #1; lat++; end
    check("lat6", 32'(lat), 32'd2);
    check("res6", {24'd0, co6, of6, s6}, {24'd0, 1'(ec), 1'(eo), 6'(es)});
    @(negedge clk);
    or6 = 1'b1;
    @(posedge clk); #1;
    or6 = 1'b0;
    check("back6", {30'd0, ov6, ir6}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    check("rst_state", {13'd0, ov16, ir16, co16, of16, s16}, {13'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000});
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    run16(16'h00FF, 16'h0001, 1'b0, 1'b0, 0);
    run16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    run16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    run16(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
    run16(16'h8000, 16'h0001, 1'b0, 1'b1, 0);
    run16(16'h8000, 16'h0000, 1'b1, 1'b1, 0);
    run16(16'h7FFF, 16'h0000, 1'b1, 1'b0, 0);
    run16(16'h1357, 16'h2468, 1'b1, 1'b0, 5);

    run6(6'd16, 6'd17, 1'b0, 1'b0);
    run6(6'd63, 6'd60, 1'b0, 1'b0);
    run6(6'd8,  6'd7,  1'b0, 1'b0);

    // Abort mid-RUN with reset.
    @(negedge clk);
    a16 = 16'hAAAA; b16 = 16'h5555; ci16 = 1'b0; sb16 = 1'b0; iv16 = 1'b1;
    @(posedge clk); #1; iv16 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort", {13'd0, ov16, ir16, co16, of16, s16}, {13'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000});
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("no_result", 32'(ov16), 32'd0);
    end
    run16(16'h1234, 16'h1111, 1'b0, 1'b0, 0);

    for (int i = 0; i < 30; i++)
      run16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    for (int i = 0; i < 20; i++)
      run6(6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg_rca_adder.md
SEG_RCA_ADDER -- requirements
Module: seg_rca_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter SEG, default 4, bits added per clock cycle; WIDTH % SEG == 0 and SEG >= 1 are required, and elaboration SHALL fail otherwise.
REQ-003 SHALL derive local constant NSEG = WIDTH/SEG, the number of segments.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  operands and mode are valid.
REQ-008 in_ready  output  1  block can accept an operation.
REQ-009 a, b  input  WIDTH  operands.
REQ-010 cin  input  1  carry-in (add) or borrow-in (sub).
REQ-011 sub  input  1  0 = a+b+cin; 1 = a-b-cin.
REQ-012 out_valid  output  1  result is valid.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 sum  output  WIDTH  result.
REQ-015 cout  output  1  carry-out; in sub mode, 1 = no borrow.
REQ-016 ovf  output  1  two's-complement signed overflow.

Function
REQ-017 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-018 in_ready SHALL equal (state == IDLE); out_valid SHALL equal (state == DONE).
REQ-019 In IDLE, in_valid && in_ready SHALL capture a, b_eff = sub ? ~b : b, carry = sub ? ~cin : cin, clear segment index k to 0, and enter RUN.
REQ-020 Each RUN cycle SHALL compute sum[k*SEG +: SEG] = a_seg + b_eff_seg + carry, register the segment carry-out into carry, and increment k.
REQ-021 On the RUN cycle with k == NSEG-1, the block SHALL register cout = final carry-out and ovf = (carry into MSB) XOR (carry out of MSB), then enter DONE.
REQ-022 out_valid SHALL rise exactly NSEG cycles after the accepting edge.
REQ-023 In DONE, sum, cout and ovf SHALL hold stable until out_ready == 1; that edge SHALL return the FSM to IDLE.
REQ-024 in_valid SHALL be ignored outside IDLE; a, b, cin and sub are don't-care after capture.
REQ-025 Minimum issue interval SHALL be NSEG+2 cycles (one IDLE, NSEG RUN, one DONE).
REQ-026 SEG == WIDTH SHALL give single-cycle RUN; SEG == 1 SHALL give bit-serial operation.
REQ-027 Upper sum segments not yet computed SHALL hold their previous value during RUN and are not observable as valid.

Reset
REQ-028 rst_n low SHALL immediately force state=IDLE, k=0, carry=0, sum=0, cout=0, ovf=0, out_valid=0, in_ready=1, including mid-RUN or mid-DONE.
REQ-029 An aborted operation SHALL produce no result; the first operation after reset SHALL be correct.

Structure
REQ-030 FSM state encodings and the WIDTH/SEG legality check SHALL reside in shared package rca_pkg.
REQ-031 Sub-module rca_seg (SEG-bit combinational ripple-carry slice: a, b, ci -> s, co, c_msb_in) SHALL be instantiated once and time-multiplexed across segments.

Verification
REQ-032 WIDTH=16, SEG=4, add 0x00FF+0x0001, cin=0 -> sum=0x0100, cout=0, ovf=0; out_valid exactly 4 cycles after accept.
REQ-033 add 0xFFFF+0x0001 -> sum=0x0000, cout=1, ovf=0; add 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1.
REQ-034 sub 0x0005-0x0007, cin=0 -> sum=0xFFFE, cout=0, ovf=0; sub 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.
REQ-035 WIDTH=6, SEG=3: 16+17 -> sum=33 (100001), cout=0; 63+60 -> sum=59 (111011), cout=1; 8+7 -> sum=15, cout=0.
REQ-036 out_ready held low 5 cycles in DONE with in_valid toggling -> sum, cout and ovf stable, in_ready=0, no new capture; release -> IDLE on the next edge.
REQ-037 rst_n pulsed low after 2 RUN cycles -> out_valid=0 and in_ready=1 immediately, no result emitted; the next add 0x1234+0x1111 -> 0x2345.
